// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution slice: BHT counter states and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package branch_resolve_pkg;

  // 2-bit bimodal counter states; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Entries come out of reset weakly not-taken so one taken outcome flips them.
  localparam bht_state_t BHT_RESET = WNT;

  // Byte distance to the sequential instruction.
  localparam int INSTR_STEP = 4;

  // Control-transfer type flags carried with the EX instruction.
  typedef struct packed {
    logic is_br;
    logic is_jal;
    logic is_jalr;
  } cti_kind_t;

  // Saturating counter step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
    bht_state_t nxt;
    nxt = cur;
    unique case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_2bit.sv
// 2-bit bimodal branch history table: one combinational read port, one saturating update port.
// Latency: read is combinational; an update becomes visible to the read port the cycle after its edge.
// Backpressure: none; an update is applied on every edge where upd_en is high.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (all entries -> WNT)
//   rd_idx          lookup index
//   rd_taken        MSB of the addressed counter (old value during a same-index update)
//   upd_en          apply a saturating update this edge
//   upd_idx         entry to update
//   upd_taken       resolved direction: 1 increments, 0 decrements
module bht_2bit
  import branch_resolve_pkg::*;
#(
  parameter int BHT_IDX = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BHT_IDX-1:0] rd_idx,
  output logic               rd_taken,
  input  logic               upd_en,
  input  logic [BHT_IDX-1:0] upd_idx,
  input  logic               upd_taken
);

  localparam int ENTRIES = 1 << BHT_IDX;

  bht_state_t bht_q [ENTRIES];
  logic [1:0] rd_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      bht_q[upd_idx] <= bht_next(bht_q[upd_idx], upd_taken);
    end
  end

  // Read straight from the state array: a write at this edge lands after the read.
  assign rd_state = bht_q[rd_idx];
  assign rd_taken = rd_state[1];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: actual direction/target, mispredict detection, redirect pulse, BHT owner.
// Latency: redirect_valid/flush/redirect_pc are registered, one cycle after the resolving edge.
// Backpressure: ex_stall freezes resolution; no handshake on redirect, fetch must take it in the pulse cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_pc / if_pred_taken           fetch-side BHT lookup (combinational)
//   ex_valid, ex_stall              EX occupancy and pipeline hold
//   ex_is_br/ex_is_jal/ex_is_jalr   control-transfer type (at most one set)
//   ex_pc, ex_imm, ex_rs1           operands for target computation
//   comp_res                        branch comparator outcome
//   ex_pred_taken/ex_pred_target    prediction made at fetch
//   redirect_valid, redirect_pc     one-cycle corrected-PC pulse to fetch
//   flush                           kill IF/ID, mirrors redirect_valid
//   br_count, mispred_count         wrapping performance counters
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 6,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             comp_res,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  cti_kind_t       kind;
  logic            is_cti;
  logic            resolve;
  logic            actual_taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;
  logic            mispredict;
  logic            raise_redirect;
  logic            unused_if_pc_bits;

  assign kind = '{is_br: ex_is_br, is_jal: ex_is_jal, is_jalr: ex_is_jalr};
  assign is_cti = kind.is_br | kind.is_jal | kind.is_jalr;

  // While a redirect pulse is out, EX holds a wrong-path instruction: it must not resolve.
  assign resolve = ex_valid & ~ex_stall & ~redirect_valid & is_cti;

  // Target arithmetic wraps modulo 2^XLEN; JALR drops bit 0 of the sum.
  assign jalr_sum     = ex_rs1 + ex_imm;
  assign target       = kind.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  assign fall_through = ex_pc + XLEN'(INSTR_STEP);
  assign actual_taken = kind.is_br ? comp_res : 1'b1;

  // A target mismatch only matters when both sides agree the transfer is taken.
  assign mispredict = (actual_taken != ex_pred_taken) |
                      (actual_taken & ex_pred_taken & (target != ex_pred_target));

  assign raise_redirect = resolve & mispredict;

  // Pulse is self-clearing: resolve is masked by redirect_valid, so it cannot stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= raise_redirect;
      if (raise_redirect) begin
        redirect_pc <= actual_taken ? target : fall_through;
      end
    end
  end

  assign flush = redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (resolve) begin
        br_count <= br_count + 1'b1;
      end
      if (raise_redirect) begin
        mispred_count <= mispred_count + 1'b1;
      end
    end
  end

  // Only conditional branches train the predictor; jumps are always taken.
  bht_2bit #(
    .BHT_IDX (BHT_IDX)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[BHT_IDX+1:2]),
    .rd_taken  (if_pred_taken),
    .upd_en    (resolve & kind.is_br),
    .upd_idx   (ex_pc[BHT_IDX+1:2]),
    .upd_taken (comp_res)
  );

  // PC bits outside the index field play no part in the lookup.
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:BHT_IDX+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized traffic
// against a behavioural model; expectations are queued and a monitor compares them.
module tb_branch_resolve;

  localparam int XLEN    = 32;
  localparam int BHT_IDX = 6;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [XLEN-1:0]  if_pc = '0;
  logic             if_pred_taken;
  logic             ex_valid = 1'b0, ex_stall = 1'b0;
  logic             ex_is_br = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
  logic [XLEN-1:0]  ex_pc = '0, ex_imm = '0, ex_rs1 = '0;
  logic             comp_res = 1'b0, ex_pred_taken = 1'b0;
  logic [XLEN-1:0]  ex_pred_target = '0;
  logic             redirect_valid, flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(XLEN), .BHT_IDX(BHT_IDX), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_br       (ex_is_br),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .comp_res       (comp_res),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  // Type flags are mutually exclusive by construction of the decoder.
  always @(posedge clk) begin
    if (rst_n && ex_valid)
      assert ($onehot0({ex_is_br, ex_is_jal, ex_is_jalr}))
        else $error("illegal: more than one control-transfer type flag set");
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard records.
  typedef struct { int cyc; logic [31:0] pc; } redir_t;
  typedef struct { int cyc; logic [31:0] br; logic [31:0] mis; logic ifp; } state_t;
  redir_t rq[$];
  state_t sq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: counters as integers, BHT as an array of 0..3.
  int          m_bht [64];
  logic [31:0] m_br, m_mis;
  bit          m_redir;

  function automatic logic [31:0] ref_target(bit jalr, logic [31:0] pc, logic [31:0] imm,
                                             logic [31:0] rs1);
    return jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_br    = '0;
    m_mis   = '0;
    m_redir = 1'b0;
    rq.delete();
  endtask

  // One clock cycle: drive inputs mid-cycle, record what the DUT must show this
  // cycle, then advance the model across the coming edge.
  task automatic step(input bit r, input bit v, input bit st, input bit br, input bit jal,
                      input bit jalr, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input bit cr, input bit pt,
                      input logic [31:0] ptg, input logic [31:0] ifpc);
    bit          taken, mis, fire, nxt;
    logic [31:0] t;
    int          ui, ri;
    @(posedge clk);
    #2;
    rst_n = r; ex_valid = v; ex_stall = st;
    ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; comp_res = cr;
    ex_pred_taken = pt; ex_pred_target = ptg; if_pc = ifpc;
    if (!r) model_reset();
    ri = (ifpc / 4) % 64;
    sq.push_back('{cyc, m_br, m_mis, (m_bht[ri] >= 2)});
    fire = r && v && !st && !m_redir && (br || jal || jalr);
    nxt  = 1'b0;
    if (fire) begin
      taken = br ? cr : 1'b1;
      t     = ref_target(jalr, pc, imm, rs1);
      mis   = (taken != pt) || (taken && pt && (t != ptg));
      m_br  = m_br + 1;
      if (mis) begin
        m_mis = m_mis + 1;
        rq.push_back('{cyc + 1, taken ? t : pc + 32'd4});
        nxt = 1'b1;
      end
      if (br) begin
        ui = (pc / 4) % 64;
        if (cr) m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
        else    m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
      end
    end
    m_redir = nxt;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ifpc);
  endtask

  task automatic rand_step();
    int          typ;
    logic [11:0] s12;
    logic [31:0] pc, imm, rs1, ptg, ifpc;
    bit          v, st, cr, pt;
    typ  = $urandom_range(0, 2);
    v    = ($urandom_range(0, 9) != 0);
    st   = ($urandom_range(0, 4) == 0);
    pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h400 + 32'($urandom_range(0, 127)) * 4;
    s12  = 12'($urandom);
    imm  = ($urandom_range(0, 3) == 0) ? $urandom : {{20{s12[11]}}, s12};
    rs1  = $urandom;
    cr   = 1'($urandom);
    pt   = 1'($urandom);
    ptg  = ($urandom_range(0, 1) == 0) ? ref_target(typ == 2, pc, imm, rs1) : $urandom;
    ifpc = 32'h400 + 32'($urandom_range(0, 127)) * 4;
    step(1, v, st, typ == 0, typ == 1, typ == 2, pc, imm, rs1, cr, pt, ptg, ifpc);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    state_t s;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      chk("redirect_valid", 32'(redirect_valid), 32'd1);
      chk("flush", 32'(flush), 32'd1);
      chk("redirect_pc", redirect_pc, rq[0].pc);
      void'(rq.pop_front());
    end else begin
      chk("no_redirect", {30'd0, flush, redirect_valid}, 32'd0);
    end
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      chk("br_count", br_count, s.br);
      chk("mispred_count", mispred_count, s.mis);
      chk("if_pred_taken", 32'(if_pred_taken), 32'(s.ifp));
    end
  end

  initial begin
    bit hit;
    model_reset();
    // Reset held for two cycles.
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    // Mispredicted taken branch -> redirect to 0x140, BHT entry trains toward taken.
    step(1, 1, 0, 1, 0, 0, 32'h100, 32'h40, 0, 1, 0, 0, 32'h100);
    // Valid mispredicting branch in the pulse cycle is wrong-path.
    step(1, 1, 0, 1, 0, 0, 32'h104, 32'h8, 0, 1, 0, 0, 32'h100);
    idle(32'h100);
    // Predicted taken but falls through -> redirect to 0x204.
    step(1, 1, 0, 1, 0, 0, 32'h200, 32'hFFFF_FF80, 0, 0, 1, 32'h180, 32'h200);
    step(1, 1, 0, 0, 1, 0, 32'h500, 32'h20, 0, 0, 0, 0, 32'h200);
    idle(32'h200);
    // JALR with odd sum, prediction matches the cleared-bit target.
    step(1, 1, 0, 0, 0, 1, 32'h600, 32'h10, 32'h1003, 0, 1, 32'h1012, 32'h600);
    idle(32'h600);
    // Four correctly predicted taken branches at 0x300, lookup on the same PC.
    repeat (4) step(1, 1, 0, 1, 0, 0, 32'h300, 32'h40, 0, 1, 1, 32'h340, 32'h300);
    repeat (2) idle(32'h300);
    // Mispredict held by a 3-cycle stall, then released.
    repeat (3) step(1, 1, 1, 1, 0, 0, 32'h380, 32'h10, 0, 0, 1, 32'h390, 32'h380);
    step(1, 1, 0, 1, 0, 0, 32'h380, 32'h10, 0, 0, 1, 32'h390, 32'h380);
    repeat (2) idle(32'h380);
    // Randomized traffic.
    repeat (400) rand_step();
    // Run until a redirect pulse is due, then assert reset in the middle of it.
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      rand_step();
      hit = m_redir;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: no redirect pulse found to interrupt");
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
    // After release every entry reads weakly not-taken.
    for (int i = 0; i < 64; i++) idle(32'(i) * 4);
    repeat (200) rand_step();
    repeat (3) idle(32'h0);
    @(posedge clk);
    #2;
    chk("redirect_queue_drained", 32'(rq.size()), 32'd0);
    chk("state_queue_drained", 32'(sq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
